int_to_float_converter: RTL and testbench

- Multi-cycle converter: 32-bit integer (signed or unsigned) in, IEEE-754 single-precision result out.
- Produces the packed float words that the FPU's floating-point arithmetic blocks consume.
- Normalization is iterative (leading-zero shift), followed by one rounding cycle.
- Valid/ready handshake on both input and output.

---
 rtl/int_to_float_converter.sv | 145 ++++++++++++++
 tb/tb_int_to_float_converter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/int_to_float_converter.sv
// rtl/int_to_float_converter.sv - multi-cycle 32-bit integer to IEEE-754 single converter
module int_to_float_converter #(
    parameter int NORM_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    input  logic [1:0]  round_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        inexact,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] STEP     = 6'(NORM_STEP);
    localparam logic [7:0] EXP_INIT = 8'd158;

    state_t      state;
    state_t      state_nxt;

    logic        sign_q;
    logic [31:0] mag_q;
    logic [7:0]  exp_q;
    logic [1:0]  rmode_q;
    logic        zero_q;
    logic [31:0] out_data_q;
    logic        inexact_q;

    logic        cap_sign;
    logic        top_zero;
    logic [5:0]  shamt;
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_rnd;

    assign cap_sign = in_signed & in_data[31];

    // Coarse shift only when the whole top window is clear, so the MSB is never overshot.
    assign top_zero = (mag_q[31 -: NORM_STEP] == '0);
    assign shamt    = top_zero ? STEP : 6'd1;

    assign frac   = mag_q[30:8];
    assign guard  = mag_q[7];
    assign sticky = |mag_q[6:0];
    assign lsb    = mag_q[8];

    always_comb begin
        round_up = 1'b0;
        case (rmode_q)
            2'b00:   round_up = ~sign_q & (guard | sticky);
            2'b01:   round_up = sign_q & (guard | sticky);
            2'b10:   round_up = guard & (sticky | lsb);
            default: round_up = 1'b0;
        endcase
    end

    assign frac_sum = {1'b0, frac} + {23'd0, round_up};
    assign exp_rnd  = exp_q + {7'd0, frac_sum[23]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid) state_nxt = NORM;
            NORM:  if ((mag_q == 32'd0) || mag_q[31]) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q     <= 1'b0;
            mag_q      <= 32'd0;
            exp_q      <= 8'd0;
            rmode_q    <= 2'd0;
            zero_q     <= 1'b0;
            out_data_q <= 32'd0;
            inexact_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q  <= cap_sign;
                        mag_q   <= cap_sign ? (32'd0 - in_data) : in_data;
                        rmode_q <= round_mode;
                        exp_q   <= EXP_INIT;
                        zero_q  <= 1'b0;
                    end
                end
                NORM: begin
                    if (mag_q == 32'd0) begin
                        zero_q <= 1'b1;
                    end else if (!mag_q[31]) begin
                        mag_q <= mag_q << shamt;
                        exp_q <= exp_q - {2'd0, shamt};
                    end
                end
                ROUND: begin
                    if (zero_q) begin
                        out_data_q <= 32'd0;
                        inexact_q  <= 1'b0;
                    end else begin
                        out_data_q <= {sign_q, exp_rnd, frac_sum[22:0]};
                        inexact_q  <= guard | sticky;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_data_q;
    assign inexact  = inexact_q;

endmodule

// File: tb/tb_int_to_float_converter.sv
// tb/tb_int_to_float_converter.sv - directed-vector bench for int_to_float_converter
module tb_int_to_float_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic [1:0]  round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        inexact;
    logic        busy;

    int total;
    int bad;

    int_to_float_converter #(.NORM_STEP(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_signed  (in_signed),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .inexact    (inexact),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Accept one operand, measure edges to out_valid, check result, optionally stall, then hand off.
    task automatic convert(input string tag, input logic [31:0] d, input logic sgn, input logic [1:0] rm,
                           input logic [31:0] exp_data, input logic exp_inx, input int exp_lat,
                           input int hold);
        int n;
        int rdy_seen;
        int unstable;
        @(negedge clk);
        in_data    = d;
        in_signed  = sgn;
        round_mode = rm;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_data    = 32'hDEAD_BEEF;
        in_signed  = ~sgn;
        round_mode = ~rm;
        n = 0;
        rdy_seen = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (in_ready) rdy_seen++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_in_ready_low"}, rdy_seen, 0);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_inexact"}, {31'd0, inexact}, {31'd0, exp_inx});
        if (hold > 0) begin
            unstable = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = (i % 2 == 0);
                in_data  = 32'h0000_0005;
                @(posedge clk);
                #1;
                if (!out_valid || out_data !== exp_data || inexact !== exp_inx || in_ready) unstable++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, "_hold_stable"}, unstable, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_idle({tag, "_after"});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        in_signed  = 1'b0;
        round_mode = 2'b10;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_out_data", out_data, 32'd0);
        check("reset_inexact", {31'd0, inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert("one_s_rne",     32'h0000_0001, 1'b1, 2'b10, 32'h3F80_0000, 1'b0, 33, 0);
        convert("m1_s_rne",      32'hFFFF_FFFF, 1'b1, 2'b10, 32'hBF80_0000, 1'b0, 33, 0);
        convert("max_u_rne",     32'hFFFF_FFFF, 1'b0, 2'b10, 32'h4F80_0000, 1'b1, 2, 0);
        convert("max_u_rz",      32'hFFFF_FFFF, 1'b0, 2'b11, 32'h4F7F_FFFF, 1'b1, 2, 0);
        convert("tie_rne",       32'h0100_0001, 1'b0, 2'b10, 32'h4B80_0000, 1'b1, 9, 0);
        convert("tie_rup",       32'h0100_0001, 1'b0, 2'b00, 32'h4B80_0001, 1'b1, 9, 0);
        convert("tie_rdn",       32'h0100_0001, 1'b0, 2'b01, 32'h4B80_0000, 1'b1, 9, 0);
        convert("smax_rne",      32'h7FFF_FFFF, 1'b1, 2'b10, 32'h4F00_0000, 1'b1, 3, 0);
        convert("smax_rz",       32'h7FFF_FFFF, 1'b1, 2'b11, 32'h4EFF_FFFF, 1'b1, 3, 0);
        convert("smin",          32'h8000_0000, 1'b1, 2'b10, 32'hCF00_0000, 1'b0, 2, 0);
        convert("neg_rdn",       32'hFEFF_FFFF, 1'b1, 2'b01, 32'hCB80_0001, 1'b1, 9, 0);
        convert("zero_hold",     32'h0000_0000, 1'b1, 2'b01, 32'h0000_0000, 1'b0, 2, 10);

        @(negedge clk);
        in_data    = 32'h0000_0001;
        in_signed  = 1'b0;
        round_mode = 2'b10;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_inexact", {31'd0, inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert("three_after_rst", 32'h0000_0003, 1'b0, 2'b10, 32'h4040_0000, 1'b0, 32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
